// File: rtl/subterranean_din_packer_pkg.sv
// Shared definitions for the Subterranean din packer: lane geometry, oper and lane-size codes,
// and byte-masking helpers.
package subterranean_din_packer_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned LANE_N = 4;

  localparam logic [2:0] LANE_SIZE_FULL  = 3'b100;
  localparam logic [2:0] LANE_SIZE_EMPTY = 3'b000;

  typedef enum logic [1:0] {
    OPER_ABSORB     = 2'b00,
    OPER_ABSORB_OUT = 2'b01,
    OPER_ENC        = 2'b10,
    OPER_DEC        = 2'b11
  } oper_e;

  // Sizes 5..7 behave as a full lane.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    if (size > LANE_SIZE_FULL) begin
      return LANE_SIZE_FULL;
    end else begin
      return size;
    end
  endfunction

  function automatic logic [LANE_W-1:0] mask_word(input logic [LANE_W-1:0] data,
                                                  input logic [2:0] size);
    logic [LANE_W-1:0] masked;
    masked = {LANE_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < size) begin
        masked[8*i +: 8] = data[8*i +: 8];
      end else begin
        masked[8*i +: 8] = 8'h00;
      end
    end
    return masked;
  endfunction

endpackage

// File: rtl/subterranean_din_packer_chk.sv
// Property checker for the packer's beat encoding: no lane size may be set beyond enable_round.
module subterranean_din_packer_chk (
  input logic        clk,
  input logic        arstn,
  input logic        m_valid,
  input logic [11:0] m_din_size,
  input logic [1:0]  m_enable_round
);

  logic [11:0] allowed_s;

  // Size bits that may be non-zero for the current enable_round.
  always_comb begin
    allowed_s = 12'h000;
    case (m_enable_round)
      2'd0:    allowed_s = 12'h007;
      2'd1:    allowed_s = 12'h03F;
      2'd2:    allowed_s = 12'h1FF;
      default: allowed_s = 12'hFFF;
    endcase
  end

  a_size_within_rounds: assert property (@(posedge clk) disable iff (!arstn)
    m_valid |-> ((m_din_size & ~allowed_s) == 12'h000));

endmodule

// File: rtl/subterranean_packer_lane.sv
// One 32-bit lane of the outgoing beat: data/size register with byte masking on write.
module subterranean_packer_lane
  import subterranean_din_packer_pkg::*;
(
  input  logic              clk,
  input  logic              arstn,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [LANE_W-1:0] wr_data,
  input  logic [2:0]        wr_size,
  output logic [LANE_W-1:0] lane_data,
  output logic [2:0]        lane_size
);

  logic [LANE_W-1:0] data_r;
  logic [2:0]        size_r;

  // Lane register: a write wins over a zeroing request in the same cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data_r <= {LANE_W{1'b0}};
      size_r <= LANE_SIZE_EMPTY;
    end else if (wr_en) begin
      data_r <= mask_word(wr_data, wr_size);
      size_r <= wr_size;
    end else if (clr) begin
      data_r <= {LANE_W{1'b0}};
      size_r <= LANE_SIZE_EMPTY;
    end else begin
      data_r <= data_r;
      size_r <= size_r;
    end
  end

  assign lane_data = data_r;
  assign lane_size = size_r;

endmodule

// File: rtl/subterranean_din_packer.sv
// Packs a 32-bit word stream into 128-bit Subterranean din beats with lane-size codes.
// Optional blank-duplex generator enabled by defining SUBTERRANEAN_PACKER_BLANK_EN.
module subterranean_din_packer
  import subterranean_din_packer_pkg::*;
`ifdef SUBTERRANEAN_PACKER_BLANK_EN
#(
  parameter int unsigned BLANK_ROUNDS = 8
)
`endif
(
  input  logic         clk,
  input  logic         arstn,
  input  logic         clear,
  input  logic [31:0]  s_data,
  input  logic [2:0]   s_size,
  input  logic [1:0]   s_oper,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
`ifdef SUBTERRANEAN_PACKER_BLANK_EN
  input  logic         blank_req,
`endif
  output logic [127:0] m_din,
  output logic [11:0]  m_din_size,
  output logic [1:0]   m_enable_round,
  output logic [1:0]   m_oper,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [1:0]  lane_cnt_r, lane_cnt_nxt_s;
  logic        pad_pending_r, pad_pending_nxt_s;
  logic        m_valid_r, m_valid_nxt_s;
  logic [1:0]  er_r, er_nxt_s;
  oper_e       oper_r, oper_nxt_s;
  logic [3:0]  lane_wr_s, lane_clr_s;
  logic [2:0]  size_n_s;
  logic        accept_s, handshake_s, term_s, full_s, blank_busy_s;
  logic [LANE_W-1:0] lane_data_s [LANE_N];
  logic [2:0]        lane_size_s [LANE_N];

`ifdef SUBTERRANEAN_PACKER_BLANK_EN
  localparam int unsigned BLANK_BEATS   = (BLANK_ROUNDS + 3) / 4;
  localparam logic [2:0]  BLANK_BEATS_C = 3'(BLANK_BEATS);
  localparam logic [1:0]  BLANK_LAST_ER = 2'((BLANK_ROUNDS - 1) % 4);
  logic       blank_busy_r, blank_busy_nxt_s;
  logic [2:0] blank_cnt_r, blank_cnt_nxt_s;
  assign blank_busy_s = blank_busy_r;
`else
  assign blank_busy_s = 1'b0;
`endif

  assign size_n_s    = norm_size(s_size);
  assign full_s      = (size_n_s == LANE_SIZE_FULL);
  assign term_s      = s_last | ~full_s;
  assign s_ready     = ~pad_pending_r & ~blank_busy_s & (~m_valid_r | m_ready);
  assign accept_s    = s_valid & s_ready & ~clear;
  assign handshake_s = m_valid_r & m_ready;

  // Next-state: clear, then word accept, then pad beat, then blank sequence.
  always_comb begin
    lane_cnt_nxt_s    = lane_cnt_r;
    pad_pending_nxt_s = pad_pending_r;
    m_valid_nxt_s     = m_valid_r & ~m_ready;
    er_nxt_s          = er_r;
    oper_nxt_s        = oper_r;
    lane_wr_s         = 4'b0000;
    lane_clr_s        = 4'b0000;
`ifdef SUBTERRANEAN_PACKER_BLANK_EN
    blank_busy_nxt_s  = blank_busy_r;
    blank_cnt_nxt_s   = blank_cnt_r;
`endif
    if (clear) begin
      m_valid_nxt_s     = 1'b0;
      lane_cnt_nxt_s    = 2'd0;
      pad_pending_nxt_s = 1'b0;
      lane_clr_s        = 4'b1111;
`ifdef SUBTERRANEAN_PACKER_BLANK_EN
      blank_busy_nxt_s  = 1'b0;
      blank_cnt_nxt_s   = 3'd0;
`endif
    end else if (accept_s) begin
      lane_wr_s[lane_cnt_r] = 1'b1;
      if (lane_cnt_r == 2'd0) begin
        lane_clr_s = 4'b1110;
        oper_nxt_s = oper_e'(s_oper);
      end else begin
        lane_clr_s = 4'b0000;
      end
      if (term_s && full_s) begin
        // Full terminating word: the trailing empty lane is already zero in the lane regs.
        m_valid_nxt_s  = 1'b1;
        lane_cnt_nxt_s = 2'd0;
        if (lane_cnt_r == 2'd3) begin
          er_nxt_s          = 2'd3;
          pad_pending_nxt_s = 1'b1;
        end else begin
          er_nxt_s = lane_cnt_r + 2'd1;
        end
      end else if (term_s || (lane_cnt_r == 2'd3)) begin
        m_valid_nxt_s  = 1'b1;
        lane_cnt_nxt_s = 2'd0;
        er_nxt_s       = lane_cnt_r;
      end else begin
        lane_cnt_nxt_s = lane_cnt_r + 2'd1;
      end
    end else if (pad_pending_r && handshake_s) begin
      m_valid_nxt_s     = 1'b1;
      er_nxt_s          = 2'd0;
      lane_clr_s        = 4'b1111;
      pad_pending_nxt_s = 1'b0;
    end
`ifdef SUBTERRANEAN_PACKER_BLANK_EN
    else if (blank_busy_r && (!m_valid_r || m_ready)) begin
      m_valid_nxt_s = 1'b1;
      lane_clr_s    = 4'b1111;
      oper_nxt_s    = OPER_ABSORB;
      if (blank_cnt_r == 3'd1) begin
        er_nxt_s         = BLANK_LAST_ER;
        blank_busy_nxt_s = 1'b0;
      end else begin
        er_nxt_s         = 2'd3;
        blank_busy_nxt_s = 1'b1;
      end
      blank_cnt_nxt_s = blank_cnt_r - 3'd1;
    end else if (blank_req && !blank_busy_r && (lane_cnt_r == 2'd0) && !pad_pending_r) begin
      blank_busy_nxt_s = 1'b1;
      blank_cnt_nxt_s  = BLANK_BEATS_C;
    end
`endif
    else begin
      lane_wr_s = 4'b0000;
    end
  end

  // Control and beat-header registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      lane_cnt_r    <= 2'd0;
      pad_pending_r <= 1'b0;
      m_valid_r     <= 1'b0;
      er_r          <= 2'd0;
      oper_r        <= OPER_ABSORB;
    end else begin
      lane_cnt_r    <= lane_cnt_nxt_s;
      pad_pending_r <= pad_pending_nxt_s;
      m_valid_r     <= m_valid_nxt_s;
      er_r          <= er_nxt_s;
      oper_r        <= oper_nxt_s;
    end
  end

`ifdef SUBTERRANEAN_PACKER_BLANK_EN
  // Blank-duplex sequencer state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      blank_busy_r <= 1'b0;
      blank_cnt_r  <= 3'd0;
    end else begin
      blank_busy_r <= blank_busy_nxt_s;
      blank_cnt_r  <= blank_cnt_nxt_s;
    end
  end
`endif

  for (genvar k = 0; k < LANE_N; k++) begin : g_lane
    subterranean_packer_lane u_lane (
      .clk       (clk),
      .arstn     (arstn),
      .wr_en     (lane_wr_s[k]),
      .clr       (lane_clr_s[k]),
      .wr_data   (s_data),
      .wr_size   (size_n_s),
      .lane_data (lane_data_s[k]),
      .lane_size (lane_size_s[k])
    );
    assign m_din[32*k +: 32]    = lane_data_s[k];
    assign m_din_size[3*k +: 3] = lane_size_s[k];
  end

  assign m_valid        = m_valid_r;
  assign m_enable_round = er_r;
  assign m_oper         = oper_r;

endmodule
